// File: rtl/pwm_playback_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and constants for the PWM playback controller
//               and the pwmdac integration (state encoding, midscale value,
//               default sample-period divider).
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Clocks per sample period: 2^SAMPLE_WIDTH clocks per PWM pulse times
    // four pulses per sample at the default 8-bit width.
    localparam int c_DEFAULT_TICK_DIV = 1024;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        CAPTURE   = 3'd2,
        WAIT_TICK = 3'd3,
        DRAIN     = 3'd4
    } state_t;

    // Code that drives the DAC to 50 % duty, i.e. silence.
    function automatic int unsigned midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_playback_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_playback_ctrl_if
// Description : Sample-RAM read port. Read data is valid exactly one cycle
//               after the strobe.
//   mem_rd   : read strobe            (master -> slave)
//   mem_addr : read address           (master -> slave)
//   mem_data : read data              (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_playback_ctrl_if #(
    parameter int ADDR_WIDTH   = 16,
    parameter int SAMPLE_WIDTH = 8
);
    logic                    mem_rd;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [SAMPLE_WIDTH-1:0] mem_data;

    modport master (output mem_rd, output mem_addr, input  mem_data);
    modport slave  (input  mem_rd, input  mem_addr, output mem_data);
endinterface
`default_nettype wire

// File: rtl/pwm_playback_ctrl_sample_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : sample_tick_gen
// Description : Sample-period divider. Counts 0..TICK_DIV-1 while enabled
//               and flags the last count; held at zero when disabled or
//               cleared.
//   clk, rst  : clock, synchronous active-high reset
//   i_clear   : force count to zero
//   i_enable  : count while high
//   o_tick    : high while count == TICK_DIV-1 (and enabled)
// Revision    : 1.0 - initial release
// ============================================================================
module sample_tick_gen
    import pwm_pkg::*;
#(
    parameter int TICK_DIV = c_DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);
    localparam int                 c_CNT_W = $clog2(TICK_DIV);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TICK_DIV - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear || !i_enable) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick = i_enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/pwm_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_playback_ctrl
// Description : Plays a run of samples from sample RAM into the PWM DAC,
//               one sample per TICK_DIV clocks. One-shot or looped, with
//               abort; outputs midscale while idle.
//   clk, rst        : clock, synchronous active-high reset
//   i_start/i_stop  : one-cycle command pulses (stop wins)
//   i_loop_en       : reload base/length at end of each run
//   i_base_addr     : first sample address
//   i_length        : samples per run (0 = start ignored)
//   mem_if          : sample-RAM read port (master)
//   o_sample        : registered sample to pwmdac
//   o_sample_tick   : pulse in the cycle o_sample loads a memory value
//   o_busy          : not idle
//   o_done          : pulse on normal completion
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_playback_ctrl
    import pwm_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int TICK_DIV     = c_DEFAULT_TICK_DIV
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic                    i_loop_en,
    input  logic [ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [ADDR_WIDTH-1:0]   i_length,
    pwm_playback_ctrl_if.master     mem_if,
    output logic [SAMPLE_WIDTH-1:0] o_sample,
    output logic                    o_sample_tick,
    output logic                    o_busy,
    output logic                    o_done
);
    localparam logic [SAMPLE_WIDTH-1:0] c_MIDSCALE = SAMPLE_WIDTH'(midscale(SAMPLE_WIDTH));

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_cur_addr;
    logic [ADDR_WIDTH-1:0]   r_remaining;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [SAMPLE_WIDTH-1:0] r_pf;
    logic [SAMPLE_WIDTH-1:0] r_sample;
    logic                    w_tick;
    logic                    w_busy;
    logic                    w_abort;
    logic                    w_accept;
    logic                    w_more;
    logic                    w_reload;
    logic                    w_clear;

    assign w_busy   = (r_state != IDLE);
    assign w_abort  = i_stop && w_busy;
    assign w_accept = (r_state == IDLE) && i_start && !i_stop && (i_length != '0);
    assign w_more   = (r_remaining != '0);
    assign w_reload = !w_more && i_loop_en && (i_length != '0);
    // Zero the divider in idle and on the way into idle, so a new start
    // always sees a full period before its first sample.
    assign w_clear  = !w_busy || (w_next == IDLE);

    sample_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_enable (w_busy),
        .o_tick   (w_tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides everything including a tick
    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:      if (w_accept) w_next = FETCH;
                FETCH:     w_next = CAPTURE;
                CAPTURE:   w_next = WAIT_TICK;
                WAIT_TICK: if (w_tick) w_next = (w_more || w_reload) ? FETCH : DRAIN;
                DRAIN:     if (w_tick) w_next = IDLE;
                default:   w_next = IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        mem_if.mem_rd = 1'b0;
        o_sample_tick = 1'b0;
        o_done        = 1'b0;
        if (!w_abort) begin
            case (r_state)
                FETCH:     mem_if.mem_rd = 1'b1;
                WAIT_TICK: o_sample_tick = w_tick;
                DRAIN:     o_done        = w_tick;
                default:   ;
            endcase
        end
    end

    // Datapath. r_mem_addr is loaded only on entry to FETCH so the address
    // holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_mem_addr  <= '0;
            r_pf        <= '0;
            r_sample    <= c_MIDSCALE;
        end else if (w_abort) begin
            r_sample    <= c_MIDSCALE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cur_addr  <= i_base_addr;
                        r_remaining <= i_length;
                        r_mem_addr  <= i_base_addr;
                    end
                end
                FETCH: begin
                    r_cur_addr  <= r_cur_addr + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                end
                CAPTURE: begin
                    r_pf <= mem_if.mem_data;
                end
                WAIT_TICK: begin
                    if (w_tick) begin
                        r_sample <= r_pf;
                        if (w_more) begin
                            r_mem_addr <= r_cur_addr;
                        end else if (w_reload) begin
                            r_cur_addr  <= i_base_addr;
                            r_remaining <= i_length;
                            r_mem_addr  <= i_base_addr;
                        end
                    end
                end
                DRAIN: begin
                    if (w_tick) r_sample <= c_MIDSCALE;
                end
                default: ;
            endcase
        end
    end

    assign mem_if.mem_addr = r_mem_addr;
    assign o_sample        = r_sample;
    assign o_busy          = w_busy;

endmodule
`default_nettype wire

// File: doc/pwm_playback_ctrl.md
Name: pwm_playback_ctrl

Overview:
Sequences audio playback into the PWM DAC. On command, it fetches a run of samples from sample memory and presents one sample per sample period. The sample period is set by an internal clock divider matched to the DAC's pulse frame. It sits between the recorder's sample RAM (read port) and the pwmdac sample input. It supports one-shot and looped playback, abort, and midscale (silent) output when idle.

Parameters:
SAMPLE_WIDTH, 8, bit width of samples and of mem_data/sample.
ADDR_WIDTH, 16, sample memory address width.
TICK_DIV, 1024, clocks per sample period (2^SAMPLE_WIDTH x PWM pulses per sample); must be >= 4.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins playback when idle.
stop  input  1  one-cycle pulse; aborts playback.
loop_en  input  1  restart from base_addr at end of run; sampled at end of each run.
base_addr  input  ADDR_WIDTH  first sample address; sampled at start and at each loop reload.
length  input  ADDR_WIDTH  number of samples per run; sampled at start and at each loop reload.
mem_rd  output  1  read strobe to sample RAM.
mem_addr  output  ADDR_WIDTH  read address, valid while mem_rd=1.
mem_data  input  SAMPLE_WIDTH  read data, valid exactly 1 cycle after mem_rd.
sample  output  SAMPLE_WIDTH  registered sample to pwmdac.
sample_tick  output  1  one-cycle pulse in the cycle sample takes a new memory value.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse on normal completion (not on stop).

Behaviour:
- Reset (rst=1 at clock edge): state IDLE, sample=MIDSCALE (2^(SAMPLE_WIDTH-1), e.g. 8'h80), mem_rd=0, mem_addr=0, sample_tick=0, done=0, busy=0, divider=0. Reset mid-playback behaves identically; there is no residual output.
- Divider: counts 0..TICK_DIV-1 while busy and wraps to 0. The tick is asserted when the count equals TICK_DIV-1. The divider is cleared to 0 on the start-accept cycle and held at 0 in IDLE.
- Internal registers: cur_addr (ADDR_WIDTH), remaining (ADDR_WIDTH, samples not yet fetched), pf (prefetch, SAMPLE_WIDTH).
- States:
  - IDLE: on start=1, stop=0, length!=0: cur_addr<=base_addr, remaining<=length, divider<=0, go to FETCH. A start with length==0 is ignored and done is not pulsed.
  - FETCH (1 cycle): mem_rd=1, mem_addr=cur_addr; cur_addr<=cur_addr+1 (wraps modulo 2^ADDR_WIDTH); remaining<=remaining-1; go to CAPTURE.
  - CAPTURE (1 cycle): pf<=mem_data; go to WAIT_TICK.
  - WAIT_TICK: on tick: sample<=pf, sample_tick=1. Then:
    - if remaining!=0, go to FETCH;
    - else if loop_en=1 and length!=0, cur_addr<=base_addr, remaining<=length, go to FETCH;
    - else go to DRAIN.
  - DRAIN: holds the last sample for one full period. On tick: sample<=MIDSCALE, done=1, go to IDLE.
- Timing: the first sample appears at clock cycle TICK_DIV after the start-accept cycle. Each subsequent sample follows exactly TICK_DIV cycles later, with no gap across loop reloads. The 2-cycle fetch always completes before the next tick because TICK_DIV>=4.
- stop=1 in any non-IDLE state: next state IDLE, sample<=MIDSCALE, mem_rd=0, done=0, sample_tick=0. stop has priority over a tick in the same cycle. stop in IDLE has no effect.
- start while busy is ignored. If start and stop arrive in the same IDLE cycle, stop wins and the block remains IDLE.
- mem_rd is high only in FETCH. mem_addr holds its last value otherwise.
- done and sample_tick are never high in the same cycle except at DRAIN completion, where sample_tick=0.

Decomposition:
- Shared package pwm_pkg:
  - state enum {IDLE, FETCH, CAPTURE, WAIT_TICK, DRAIN};
  - MIDSCALE constant/function of SAMPLE_WIDTH;
  - default TICK_DIV constant shared with pwmdac integration.
- One sub-module, sample_tick_gen: parameter TICK_DIV; ports clk, rst, clear, enable, tick.

Test Plan:
1. TICK_DIV=8, mem[10..12]={11,22,33}, base=10, length=3, loop_en=0, start at cycle 0 -> sample=11 at cycle 8, 22 at 16, 33 at 24, MIDSCALE and done at 32; sample_tick at 8/16/24 only; mem_rd at cycles 1,9,17 with addr 10,11,12.
2. Same setup, stop at cycle 12 -> sample=MIDSCALE from cycle 13, busy=0, no done, no further mem_rd.
3. loop_en=1, length=2, mem[0..1]={5,6} -> sample sequence 5,6,5,6,... every 8 cycles with no gap; clearing loop_en before the second run end -> DRAIN then done.
4. start with length=0 -> busy stays 0, no mem_rd, no done; start pulsed while busy -> sequence unchanged.
5. base=16'hFFFF, length=2 -> mem_addr FFFF then 0000.
6. rst asserted mid-WAIT_TICK -> all outputs at reset values next cycle; a new start afterwards plays correctly from base_addr.
